// File: rtl/full_handshake_tx_arb.sv
// Round-robin arbiter sharing one four-phase CDC transmitter between NUM_REQ
// TX-domain requesters; issues a one-cycle request and tracks idle through the handshake.
module full_handshake_tx_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DW      = 32,
  parameter int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ*DW-1:0] req_data_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic [NUM_REQ-1:0]    done_o,
  output logic                  busy_o,
  output logic [IW-1:0]         owner_o,
  input  logic                  tx_idle_i,
  output logic                  tx_req_o,
  output logic [DW-1:0]         tx_req_data_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_LOW,
    S_WAIT_HIGH
  } state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               busy_q, busy_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic               tx_req_q, tx_req_d;
  logic [DW-1:0]      tx_data_q, tx_data_d;

  logic               win_found;
  logic [IW-1:0]      win_idx;
  logic [DW-1:0]      win_data;
  int unsigned        scan;

  // Rotating-priority search: first pending requester at or above the pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan = 32'(ptr_q) + i;
      if (scan >= NUM_REQ) scan = scan - NUM_REQ;
      if (!win_found && req_i[IW'(scan)]) begin
        win_found = 1'b1;
        win_idx   = IW'(scan);
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (win_idx == IW'(k)) win_data = req_data_i[k*DW +: DW];
    end
  end

  // Next-state and registered-output logic; strobes default low every cycle.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = '0;
    done_d    = '0;
    tx_req_d  = 1'b0;
    tx_data_d = '0;
    busy_d    = busy_q;
    owner_d   = owner_q;
    case (state_q)
      S_IDLE: begin
        if (tx_idle_i && win_found) begin
          tx_req_d  = 1'b1;
          tx_data_d = win_data;
          gnt_d     = NUM_REQ'(1) << win_idx;
          owner_d   = win_idx;
          busy_d    = 1'b1;
          ptr_d     = (32'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + IW'(1);
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (!tx_idle_i) state_d = S_WAIT_HIGH;
      end
      S_WAIT_HIGH: begin
        if (tx_idle_i) begin
          done_d  = NUM_REQ'(1) << owner_q;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      owner_q   <= '0;
      tx_req_q  <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      owner_q   <= owner_d;
      tx_req_q  <= tx_req_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign gnt_o         = gnt_q;
  assign done_o        = done_q;
  assign busy_o        = busy_q;
  assign owner_o       = owner_q;
  assign tx_req_o      = tx_req_q;
  assign tx_req_data_o = tx_data_q;

endmodule

// File: tb/tb_full_handshake_tx_arb.sv
// Directed bench for full_handshake_tx_arb with a behavioural transmitter that
// drops idle the cycle after a request and holds it low for six cycles.
module tb_full_handshake_tx_arb;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_i;
  logic [127:0] req_data_i;
  logic [3:0]  gnt_o;
  logic [3:0]  done_o;
  logic        busy_o;
  logic [1:0]  owner_o;
  logic        tx_idle_i;
  logic        tx_req_o;
  logic [31:0] tx_req_data_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] dat [4];
  logic        m_idle;
  int          m_cnt;
  logic        stall;

  full_handshake_tx_arb #(.NUM_REQ(4), .DW(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         (req_i),
    .req_data_i    (req_data_i),
    .gnt_o         (gnt_o),
    .done_o        (done_o),
    .busy_o        (busy_o),
    .owner_o       (owner_o),
    .tx_idle_i     (tx_idle_i),
    .tx_req_o      (tx_req_o),
    .tx_req_data_o (tx_req_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter stand-in, reset by the same rst_n; stall forces idle low.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle <= 1'b1;
      m_cnt  <= 0;
    end else if (tx_req_o) begin
      m_idle <= 1'b0;
      m_cnt  <= 6;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_idle <= 1'b1;
    end
  end
  assign tx_idle_i = m_idle & ~stall;

  function automatic logic [31:0] oh(input int k);
    return 32'(1) << k;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a grant and check the ISSUE-cycle outputs.
  task automatic issue(input int k, input string tag);
    int n = 0;
    while (gnt_o == 4'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".gnt"},   32'(gnt_o),   oh(k));
    chk({tag, ".txreq"}, 32'(tx_req_o), 32'd1);
    chk({tag, ".data"},  tx_req_data_o, dat[k]);
    chk({tag, ".owner"}, 32'(owner_o), 32'(k));
    chk({tag, ".busy"},  32'(busy_o),  32'd1);
  endtask

  // Check the pulse ends, then wait (bounded) for idle to return and check done.
  task automatic finish(input int k, input string tag);
    int n = 0;
    @(negedge clk);
    chk({tag, ".gnt_end"},   32'(gnt_o),   32'd0);
    chk({tag, ".txreq_end"}, 32'(tx_req_o), 32'd0);
    chk({tag, ".data_end"},  tx_req_data_o, 32'd0);
    while (!tx_idle_i && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".idle_back"}, 32'(tx_idle_i), 32'd1);
    chk({tag, ".done_early"}, 32'(done_o), 32'd0);
    @(negedge clk);
    chk({tag, ".done"},  32'(done_o), oh(k));
    chk({tag, ".busy_end"}, 32'(busy_o), 32'd0);
    chk({tag, ".owner_hold"}, 32'(owner_o), 32'(k));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dat[0] = 32'hA000_0000;
    dat[1] = 32'hA111_1111;
    dat[2] = 32'hDEAD_BEEF;
    dat[3] = 32'hA333_3333;
    req_data_i = {dat[3], dat[2], dat[1], dat[0]};
    rst_n = 1'b0;
    req_i = 4'b0;
    stall = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.gnt",   32'(gnt_o),   32'd0);
    chk("rst.done",  32'(done_o),  32'd0);
    chk("rst.busy",  32'(busy_o),  32'd0);
    chk("rst.owner", 32'(owner_o), 32'd0);
    chk("rst.txreq", 32'(tx_req_o), 32'd0);
    chk("rst.data",  tx_req_data_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request: grant visible one cycle after the request is sampled.
    req_i = 4'b0100;
    @(negedge clk);
    issue(2, "single");
    req_i = 4'b0;
    finish(2, "single");

    // Pointer wrap: 3 first, then {3,0} pending -> 0 then 3.
    req_i = 4'b1000;
    issue(3, "wrap3a");
    req_i = 4'b1001;
    finish(3, "wrap3a");
    issue(0, "wrap0");
    req_i = 4'b1000;
    finish(0, "wrap0");
    issue(3, "wrap3b");
    req_i = 4'b0;
    finish(3, "wrap3b");

    // Round-robin with all held: 0,1,2,3,0.
    req_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      issue(i % 4, $sformatf("rr%0d", i));
      if (i == 4) req_i = 4'b0;
      finish(i % 4, $sformatf("rr%0d", i));
    end

    // Late request while busy with 0; next tx_req follows done by one cycle.
    req_i = 4'b0001;
    issue(0, "late0");
    req_i = 4'b0010;
    finish(0, "late0");
    @(negedge clk);
    chk("b2b.txreq", 32'(tx_req_o), 32'd1);
    chk("b2b.gnt",   32'(gnt_o),   oh(1));
    issue(1, "late1");
    req_i = 4'b0;
    finish(1, "late1");

    // Stall: no issue while transmitter reports busy.
    stall = 1'b1;
    req_i = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d.txreq", i), 32'(tx_req_o), 32'd0);
    end
    stall = 1'b0;
    @(negedge clk);
    chk("unstall.txreq", 32'(tx_req_o), 32'd1);
    issue(0, "unstall");
    req_i = 4'b0;
    finish(0, "unstall");

    // Reset in WAIT_HIGH: outputs clear at once and done is lost.
    req_i = 4'b0010;
    issue(1, "mid");
    req_i = 4'b0;
    repeat (3) @(negedge clk);
    chk("mid.busy_pre", 32'(busy_o), 32'd1);
    chk("mid.idle_pre", 32'(tx_idle_i), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("arst.busy",  32'(busy_o),  32'd0);
    chk("arst.owner", 32'(owner_o), 32'd0);
    chk("arst.gnt",   32'(gnt_o),   32'd0);
    chk("arst.txreq", 32'(tx_req_o), 32'd0);
    chk("arst.data",  tx_req_data_o, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("arst%0d.done", i), 32'(done_o), 32'd0);
    end
    rst_n = 1'b1;
    req_i = 4'b1111;
    @(negedge clk);
    issue(0, "post_rst");
    req_i = 4'b0;
    finish(0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
